// File: rtl/cuca1_pkg.sv
// Shared types for the cuca1 datapath: control-pin map, microword layout and
// sequencer field encodings.
package cuca1_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int UPC_W_DEF  = 7;
  localparam int OPC_W_DEF  = 4;

  typedef enum logic [3:0] {
    PIN_PC_INC   = 4'd0,
    PIN_PC_LD    = 4'd1,
    PIN_IR_LD    = 4'd2,
    PIN_A_LD     = 4'd3,
    PIN_B_LD     = 4'd4,
    PIN_ALU_OE   = 4'd5,
    PIN_MEM_RD   = 4'd6,
    PIN_MEM_WR   = 4'd7,
    PIN_MAR_LD   = 4'd8,
    PIN_MDR_LD   = 4'd9,
    PIN_MDR_OE   = 4'd10,
    PIN_ALU_OP0  = 4'd11,
    PIN_ALU_OP1  = 4'd12,
    PIN_FLAGS_LD = 4'd13,
    PIN_OUT_LD   = 4'd14,
    PIN_HALT     = 4'd15
  } enum_microprogram_pin;

  localparam int MEM_RD_BIT_DEF = PIN_MEM_RD;
  localparam int MEM_WR_BIT_DEF = PIN_MEM_WR;
  localparam int HALT_BIT_DEF   = PIN_HALT;

  typedef enum logic [1:0] {
    SEQ_NEXT     = 2'd0,
    SEQ_JUMP     = 2'd1,
    SEQ_DISPATCH = 2'd2,
    SEQ_END      = 2'd3
  } seq_t;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_ZERO   = 2'd1,
    COND_CARRY  = 2'd2,
    COND_NZERO  = 2'd3
  } cond_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HALTED   = 2'd2
  } useq_state_t;

  // Bit offsets of the microword fields above the control-pin field.
  localparam int UW_SEQ_LSB    = CTRL_W_DEF;
  localparam int UW_COND_LSB   = CTRL_W_DEF + 2;
  localparam int UW_TARGET_LSB = CTRL_W_DEF + 4;
  localparam int UWORD_W       = CTRL_W_DEF + 4 + UPC_W_DEF;

  typedef struct packed {
    logic [UPC_W_DEF-1:0]  target;
    cond_t                 cond;
    seq_t                  seq;
    logic [CTRL_W_DEF-1:0] ctrl;
  } microword_t;

  function automatic logic cond_met(input cond_t c, input logic zero,
                                    input logic carry);
    logic r;
    r = 1'b1;
    case (c)
      COND_ALWAYS: r = 1'b1;
      COND_ZERO:   r = zero;
      COND_CARRY:  r = carry;
      COND_NZERO:  r = ~zero;
      default:     r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cuca1_useq_next.sv
// Next micro-PC selection: purely combinational, evaluated for the line that
// is currently addressed by the sequencer.
module cuca1_useq_next
  import cuca1_pkg::*;
#(
  parameter int UPC_W = UPC_W_DEF,
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic [1:0]       i_seq,
  input  logic [1:0]       i_cond,
  input  logic             i_alu_zero,
  input  logic             i_alu_carry,
  input  logic [UPC_W-1:0] i_target,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [UPC_W-1:0] i_upc,
  output logic [UPC_W-1:0] o_upc_nxt
);

  seq_t             w_seq;
  cond_t            w_cond;
  logic [UPC_W-1:0] w_upc_inc;
  logic [UPC_W-1:0] w_dispatch;

  assign w_seq  = seq_t'(i_seq);
  assign w_cond = cond_t'(i_cond);

  // Both sums wrap naturally at the micro-PC width.
  assign w_upc_inc  = i_upc + UPC_W'(1);
  assign w_dispatch = i_target + UPC_W'(i_opcode);

  always_comb begin
    o_upc_nxt = w_upc_inc;
    case (w_seq)
      SEQ_NEXT:     o_upc_nxt = w_upc_inc;
      SEQ_JUMP:     o_upc_nxt = cond_met(w_cond, i_alu_zero, i_alu_carry)
                                ? i_target : w_upc_inc;
      SEQ_DISPATCH: o_upc_nxt = w_dispatch;
      SEQ_END:      o_upc_nxt = '0;
      default:      o_upc_nxt = w_upc_inc;
    endcase
  end

endmodule

// File: rtl/cuca1_useq.sv
// cuca1 microprogram sequencer: addresses the microcode store, stalls on
// memory lines until acknowledged, and parks in HALTED on a halt line.
module cuca1_useq
  import cuca1_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int UPC_W      = UPC_W_DEF,
  parameter int OPC_W      = OPC_W_DEF,
  parameter int MEM_RD_BIT = MEM_RD_BIT_DEF,
  parameter int MEM_WR_BIT = MEM_WR_BIT_DEF,
  parameter int HALT_BIT   = HALT_BIT_DEF
) (
  input  logic                      clock,
  input  logic                      n_reset,
  input  logic [CTRL_W+4+UPC_W-1:0] uword,
  input  logic [OPC_W-1:0]          ir_opcode,
  input  logic                      alu_zero,
  input  logic                      alu_carry,
  input  logic                      mem_ack,
  output logic [UPC_W-1:0]          upc,
  output logic [CTRL_W-1:0]         ctrl,
  output logic                      instr_done,
  output logic                      halted
);

  useq_state_t      r_state;
  useq_state_t      w_state_nxt;
  logic [UPC_W-1:0] r_upc;
  logic             r_instr_done;

  logic [CTRL_W-1:0] w_ctrl_field;
  logic [1:0]        w_seq;
  logic [1:0]        w_cond;
  logic [UPC_W-1:0]  w_target;
  logic [UPC_W-1:0]  w_upc_nxt;
  logic              w_mem_pending;
  logic              w_halt_req;
  logic              w_active;
  logic              w_retire;
  logic              w_advance;

  assign w_ctrl_field = uword[CTRL_W-1:0];
  assign w_seq        = uword[CTRL_W+:2];
  assign w_cond       = uword[CTRL_W+2+:2];
  assign w_target     = uword[CTRL_W+4+:UPC_W];

  assign w_mem_pending = w_ctrl_field[MEM_RD_BIT] | w_ctrl_field[MEM_WR_BIT];
  assign w_halt_req    = w_ctrl_field[HALT_BIT];

  // A line retires when it needs no memory or memory acknowledges it; the
  // flags and ack are therefore always sampled in the retire cycle.
  assign w_active  = (r_state != ST_HALTED);
  assign w_retire  = w_active & (~w_mem_pending | mem_ack);
  assign w_advance = w_retire & ~w_halt_req;

  cuca1_useq_next #(
    .UPC_W (UPC_W),
    .OPC_W (OPC_W)
  ) u_next (
    .i_seq       (w_seq),
    .i_cond      (w_cond),
    .i_alu_zero  (alu_zero),
    .i_alu_carry (alu_carry),
    .i_target    (w_target),
    .i_opcode    (ir_opcode),
    .i_upc       (r_upc),
    .o_upc_nxt   (w_upc_nxt)
  );

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN, ST_WAIT_MEM: begin
        if (!w_retire) begin
          w_state_nxt = ST_WAIT_MEM;
        end else if (w_halt_req) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_upc        <= '0;
      r_instr_done <= 1'b0;
    end else begin
      if (w_advance) begin
        r_upc <= w_upc_nxt;
      end
      r_instr_done <= w_advance & (seq_t'(w_seq) == SEQ_END);
    end
  end

  // The store read is combinational on upc, so a stalled line keeps its
  // control pins simply because upc holds.
  always_comb begin
    ctrl       = '0;
    halted     = (r_state == ST_HALTED);
    upc        = r_upc;
    instr_done = r_instr_done;
    if (n_reset && (r_state != ST_HALTED)) begin
      ctrl = w_ctrl_field;
    end
  end

endmodule
